conv_frame_scheduler: RTL and testbench

// Sequences frame-by-frame sample delivery from the sample ROM (blk_mem_gen) into the 1D-CONV engine.

---
 rtl/conv_frame_scheduler_if.sv | 33 +++
 rtl/conv_frame_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_conv_frame_scheduler.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_scheduler_if.sv
// Handshake and ROM bus between the frame scheduler, the sample ROM and the 1D-CONV engine.
interface conv_frame_scheduler_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
);
  logic              start;
  logic              abort;
  logic              cnn_ready;
  logic              cnn_done;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              frame_start;
  logic              frame_last;
  logic [7:0]        frame_idx;
  logic              busy;
  logic              all_done;
  logic              timeout_err;

  modport master (
    output start, abort, cnn_ready, cnn_done, rom_dout,
    input  rom_en, rom_addr, sample_out, sample_valid, frame_start, frame_last,
           frame_idx, busy, all_done, timeout_err
  );

  modport slave (
    input  start, abort, cnn_ready, cnn_done, rom_dout,
    output rom_en, rom_addr, sample_out, sample_valid, frame_start, frame_last,
           frame_idx, busy, all_done, timeout_err
  );
endinterface

// File: rtl/conv_frame_scheduler.sv
// Streams FRAME_LEN-sample frames from the sample ROM into the CONV engine, aligned to ROM latency,
// with done handshake, minimum frame period, timeout and optional looping.
//
// state     | meaning
// S_IDLE    | waiting for start && cnn_ready
// S_READ    | issuing one ROM read per cycle, k = 0..FRAME_LEN-1
// S_FLUSH   | ROM idle, draining the read-latency pipe until the last sample leaves
// S_WAIT    | waiting for cnn_done, bounded by TIMEOUT
// S_GAP     | stepping frame_idx, holding off until the minimum period has elapsed
// S_FINISH  | all frames delivered (LOOP=0), all_done asserted
module conv_frame_scheduler #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = 2048,
  parameter int NUM_FRAMES = 250,
  parameter int RD_LAT     = 2,
  parameter int MIN_PERIOD = 18000,
  parameter int TIMEOUT    = 65535,
  parameter bit LOOP       = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  conv_frame_scheduler_if.slave bus
);
  localparam int KW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PW = $clog2(MIN_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [KW-1:0]     K_LAST     = KW'(FRAME_LEN - 1);
  localparam logic [PW-1:0]     PER_TC     = PW'(MIN_PERIOD - 1);
  localparam logic [PW-1:0]     PER_MAX    = PW'(MIN_PERIOD);
  localparam logic [TW-1:0]     TO_LOAD    = TW'(TIMEOUT - 1);
  localparam logic [7:0]        IDX_LAST   = 8'(NUM_FRAMES - 1);
  localparam logic [ADDR_W-1:0] FRAME_STEP = ADDR_W'(FRAME_LEN);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [7:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [PW-1:0]     per_q, per_d;
  logic [TW-1:0]     to_q, to_d;
  logic              all_done_q, all_done_d;
  logic              terr_q, terr_d;
  logic [RD_LAT:0]   vld_q, fs_q, fl_q;
  logic [DATA_W-1:0] smp_q;
  logic              rd_en;
  logic              go;

  assign rd_en = (state_q == S_READ);
  assign go    = bus.start && bus.cnn_ready;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    idx_d      = idx_q;
    base_d     = base_q;
    to_d       = to_q;
    all_done_d = all_done_q;
    terr_d     = terr_q;

    // Period is measured from each first-address cycle, counting that cycle as 1.
    per_d = per_q;
    if (rd_en && (k_q == '0))
      per_d = PW'(1);
    else if (per_q != PER_MAX)
      per_d = per_q + 1'b1;

    case (state_q)
      S_IDLE, S_FINISH: begin
        if (go) begin
          state_d    = S_READ;
          k_d        = '0;
          idx_d      = '0;
          base_d     = '0;
          all_done_d = 1'b0;
          terr_d     = 1'b0;
        end
      end
      S_READ: begin
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_FLUSH;
          k_d     = '0;
        end
      end
      S_FLUSH: begin
        to_d = TO_LOAD;
        if (vld_q[RD_LAT] && fl_q[RD_LAT])
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.cnn_done) begin
          state_d = S_GAP;
        end else if (to_q == '0) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end else begin
          to_d = to_q - 1'b1;
        end
      end
      S_GAP: begin
        if ((idx_q == IDX_LAST) && !LOOP) begin
          state_d    = S_FINISH;
          all_done_d = 1'b1;
        end else if ((per_q >= PER_TC) && bus.cnn_ready) begin
          state_d = S_READ;
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            base_d = '0;
          end else begin
            idx_d  = idx_q + 8'd1;
            base_d = base_q + FRAME_STEP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort) begin
      state_d    = S_IDLE;
      k_d        = '0;
      idx_d      = '0;
      base_d     = '0;
      all_done_d = 1'b0;
      terr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      idx_q      <= '0;
      base_q     <= '0;
      per_q      <= '0;
      to_q       <= '0;
      all_done_q <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      per_q      <= per_d;
      to_q       <= to_d;
      all_done_q <= all_done_d;
      terr_q     <= terr_d;
    end
  end

  // Stage RD_LAT-1 marks the cycle in which rom_dout carries a requested sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      fs_q  <= '0;
      fl_q  <= '0;
      smp_q <= '0;
    end else if (bus.abort) begin
      vld_q <= '0;
      fs_q  <= '0;
      fl_q  <= '0;
      smp_q <= '0;
    end else begin
      vld_q <= {vld_q[RD_LAT-1:0], rd_en};
      fs_q  <= {fs_q[RD_LAT-1:0], rd_en && (k_q == '0)};
      fl_q  <= {fl_q[RD_LAT-1:0], rd_en && (k_q == K_LAST)};
      smp_q <= vld_q[RD_LAT-1] ? bus.rom_dout : '0;
    end
  end

  assign bus.rom_en       = rd_en;
  assign bus.rom_addr     = base_q + ADDR_W'(k_q);
  assign bus.sample_out   = smp_q;
  assign bus.sample_valid = vld_q[RD_LAT];
  assign bus.frame_start  = fs_q[RD_LAT];
  assign bus.frame_last   = fl_q[RD_LAT];
  assign bus.frame_idx    = idx_q;
  assign bus.busy         = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign bus.all_done     = all_done_q;
  assign bus.timeout_err  = terr_q;
endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Directed bench for conv_frame_scheduler: one non-looping instance (3 frames) and one looping instance (2 frames).
module tb_conv_frame_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, cnn_ready = 1'b0, cnn_done = 1'b0;
  logic sel = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv_frame_scheduler_if #(.ADDR_W(8), .DATA_W(16)) bif0 ();
  conv_frame_scheduler_if #(.ADDR_W(8), .DATA_W(16)) bif1 ();

  conv_frame_scheduler #(
    .ADDR_W(8), .DATA_W(16), .FRAME_LEN(8), .NUM_FRAMES(3), .RD_LAT(2),
    .MIN_PERIOD(40), .TIMEOUT(20), .LOOP(1'b0)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bif0.slave));

  conv_frame_scheduler #(
    .ADDR_W(8), .DATA_W(16), .FRAME_LEN(8), .NUM_FRAMES(2), .RD_LAT(2),
    .MIN_PERIOD(40), .TIMEOUT(20), .LOOP(1'b1)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bif1.slave));

  assign bif0.start     = start && !sel;
  assign bif1.start     = start && sel;
  assign bif0.abort     = abort;
  assign bif1.abort     = abort;
  assign bif0.cnn_ready = cnn_ready;
  assign bif1.cnn_ready = cnn_ready;
  assign bif0.cnn_done  = cnn_done;
  assign bif1.cnn_done  = cnn_done;

  // Two-cycle ROM model: dout = 0xA000 + addr.
  logic [7:0] r0, r1;
  always_ff @(posedge clk) begin
    r0 <= bif0.rom_addr;
    r1 <= bif1.rom_addr;
    bif0.rom_dout <= 16'hA000 + {8'h00, r0};
    bif1.rom_dout <= 16'hA000 + {8'h00, r1};
  end

  logic        o_rom_en, o_sv, o_fs, o_fl, o_busy, o_all_done, o_terr;
  logic [7:0]  o_rom_addr, o_idx;
  logic [15:0] o_so;
  always_comb begin
    o_rom_en   = sel ? bif1.rom_en       : bif0.rom_en;
    o_rom_addr = sel ? bif1.rom_addr     : bif0.rom_addr;
    o_sv       = sel ? bif1.sample_valid : bif0.sample_valid;
    o_so       = sel ? bif1.sample_out   : bif0.sample_out;
    o_fs       = sel ? bif1.frame_start  : bif0.frame_start;
    o_fl       = sel ? bif1.frame_last   : bif0.frame_last;
    o_idx      = sel ? bif1.frame_idx    : bif0.frame_idx;
    o_busy     = sel ? bif1.busy         : bif0.busy;
    o_all_done = sel ? bif1.all_done     : bif0.all_done;
    o_terr     = sel ? bif1.timeout_err  : bif0.timeout_err;
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Follows one frame from its first address cycle through the last sample; optionally pulses cnn_done
  // dd cycles after the frame_last cycle.
  task automatic do_frame(input int base, input int idx, input int dd, output int t0);
    int n;
    n = 0;
    while (o_rom_en !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("frame_begin", o_rom_en, 1);
    check("frame_idx", o_idx, idx);
    t0 = cyc;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      check("rom_en", o_rom_en, i < 8);
      if (i < 8) check("rom_addr", o_rom_addr, base + i);
      check("sample_valid", o_sv, i >= 3);
      check("sample_out", o_so, (i >= 3) ? (32'hA000 + base + i - 3) : 0);
      check("frame_start", o_fs, i == 3);
      check("frame_last", o_fl, i == 10);
      check("busy", o_busy, 1);
    end
    if (dd >= 0) begin
      repeat (dd) tick();
      cnn_done = 1'b1;
      tick();
      cnn_done = 1'b0;
    end
  endtask

  initial begin
    int t0, t1, t2, n;

    // Reset state
    tick(); tick();
    check("rst_rom_en", o_rom_en, 0);
    check("rst_rom_addr", o_rom_addr, 0);
    check("rst_sample_valid", o_sv, 0);
    check("rst_busy", o_busy, 0);
    check("rst_all_done", o_all_done, 0);
    check("rst_timeout_err", o_terr, 0);
    check("rst_frame_idx", o_idx, 0);
    rst_n = 1'b1;
    cnn_ready = 1'b1;
    tick();

    // Three frames, done 5 cycles after frame_last, period 40
    start = 1'b1;
    tick();
    start = 1'b0;
    do_frame(0, 0, 5, t0);
    do_frame(8, 1, 5, t1);
    check("period_0_1", t1 - t0, 40);
    do_frame(16, 2, 5, t2);
    check("period_1_2", t2 - t1, 40);
    check("gap_busy", o_busy, 1);
    check("gap_all_done", o_all_done, 0);
    tick();
    check("fin_all_done", o_all_done, 1);
    check("fin_busy", o_busy, 0);
    check("fin_frame_idx", o_idx, 2);
    check("fin_rom_en", o_rom_en, 0);
    repeat (3) tick();
    check("fin_all_done_sticky", o_all_done, 1);

    // Restart from FINISH, immediate done, cnn_ready held low 10 extra cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_all_done", o_all_done, 0);
    do_frame(0, 0, 1, t0);
    cnn_ready = 1'b0;
    while (cyc < t0 + 49) begin
      tick();
      if (cyc == t0 + 40) check("gap_hold_rom_en", o_rom_en, 0);
    end
    cnn_ready = 1'b1;
    do_frame(8, 1, -1, t1);
    check("period_ready_low", t1 - t0, 50);

    // No cnn_done: timeout 20 cycles after WAIT_DONE entry
    repeat (20) tick();
    check("to_busy_before", o_busy, 1);
    check("to_err_before", o_terr, 0);
    tick();
    check("to_busy_after", o_busy, 0);
    check("to_err_after", o_terr, 1);
    cnn_done = 1'b1;
    tick();
    cnn_done = 1'b0;
    tick();
    check("idle_done_ignored", o_busy, 0);
    check("to_err_sticky", o_terr, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears_err", o_terr, 0);

    // Abort in the middle of frame 1
    do_frame(0, 0, 1, t0);
    n = 0;
    while (o_rom_en !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("abort_frame_addr", o_rom_addr, 8);
    repeat (3) tick();
    check("abort_k3_addr", o_rom_addr, 11);
    check("abort_k3_idx", o_idx, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_rom_en", o_rom_en, 0);
    check("abort_busy", o_busy, 0);
    check("abort_idx", o_idx, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_sv !== 1'b0) n++;
    end
    check("abort_no_valid", n, 0);

    // Async reset mid-READ
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("pre_reset_valid", o_sv, 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_rom_en", o_rom_en, 0);
    check("areset_rom_addr", o_rom_addr, 0);
    check("areset_valid", o_sv, 0);
    check("areset_sample", o_so, 0);
    check("areset_busy", o_busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Looping instance, start held high throughout
    sel = 1'b1;
    start = 1'b1;
    tick();
    do_frame(0, 0, 5, t0);
    check("loop_all_done_0", o_all_done, 0);
    do_frame(8, 1, 5, t0);
    check("loop_busy_wrap", o_busy, 1);
    check("loop_all_done_1", o_all_done, 0);
    do_frame(0, 0, 5, t0);
    do_frame(8, 1, 5, t0);
    check("loop_all_done_3", o_all_done, 0);
    check("loop_busy_end", o_busy, 1);
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
